// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, ALUOp encodings and the packed layout of the
// main-decoder control word carried from ID into EX.
package mips_pkg;

  localparam int CTRL_W = 10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_SLT   = 2'b11
  } aluOp_e;

  // Bit positions within {RegDst,Branch,MemRead,MemToReg,ALUOp,MemWrite,ALUSrc,RegWrite,Jump}
  localparam int CTRL_REGDST   = 9;
  localparam int CTRL_BRANCH   = 8;
  localparam int CTRL_MEMREAD  = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_ALUOP_HI = 5;
  localparam int CTRL_ALUOP_LO = 4;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_ALUSRC   = 2;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_JUMP     = 0;

  function automatic logic isLoadWriter(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEMREAD] & ctrl[CTRL_REGWRITE];
  endfunction

endpackage

// File: rtl/id_ex_hazard.sv
// Load-use hazard detector: a load in EX whose destination is read by the ID
// instruction forces a one-cycle stall, unless the ID instruction is being flushed.
module id_ex_hazard #(
  parameter int REG_W = 5
) (
  input  logic             exValid,
  input  logic             exLoad,
  input  logic [REG_W-1:0] exRt,
  input  logic             idValid,
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  input  logic             flush,
  output logic             hazardStall
);

  logic loadPending;
  logic idReadsTarget;

  // rt is compared even for stores/branches; over-stalling is safe, missing one is not
  assign loadPending   = exValid & exLoad & (exRt != '0);
  assign idReadsTarget = idValid & ((exRt == idRs) | (exRt == idRt));
  assign hazardStall   = loadPending & idReadsTarget & ~flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation, bubble insertion on
// flush/stall/empty ID, and a saturating count of flush/stall bubbles.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int COUNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              flush,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic              hazard_stall,
  output logic [COUNT_W-1:0] bubble_count
);

  function automatic logic [COUNT_W-1:0] satInc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + {{(COUNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic              vld_p1;
  logic [CTRL_W-1:0] ctrl_p1;
  logic [DATA_W-1:0] pc4_p1;
  logic [DATA_W-1:0] rsData_p1;
  logic [DATA_W-1:0] rtData_p1;
  logic [DATA_W-1:0] imm_p1;
  logic [REG_W-1:0]  rs_p1;
  logic [REG_W-1:0]  rt_p1;
  logic [REG_W-1:0]  rd_p1;
  logic [COUNT_W-1:0] bubbleCnt;
  logic              hazardStall;
  logic              capture;

  id_ex_hazard #(
    .REG_W(REG_W)
  ) uHazard (
    .exValid    (vld_p1),
    .exLoad     (isLoadWriter(ctrl_p1)),
    .exRt       (rt_p1),
    .idValid    (id_valid),
    .idRs       (id_rs),
    .idRt       (id_rt),
    .flush      (flush),
    .hazardStall(hazardStall)
  );

  assign capture = id_valid & ~flush & ~hazardStall;

  // ID -> EX boundary: a bubble is an all-zero word, so no enable can leak downstream
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      ctrl_p1   <= '0;
      pc4_p1    <= '0;
      rsData_p1 <= '0;
      rtData_p1 <= '0;
      imm_p1    <= '0;
      rs_p1     <= '0;
      rt_p1     <= '0;
      rd_p1     <= '0;
      bubbleCnt <= '0;
    end else begin
      vld_p1    <= capture;
      ctrl_p1   <= capture ? id_ctrl    : '0;
      pc4_p1    <= capture ? id_pc4     : '0;
      rsData_p1 <= capture ? id_rs_data : '0;
      rtData_p1 <= capture ? id_rt_data : '0;
      imm_p1    <= capture ? id_imm     : '0;
      rs_p1     <= capture ? id_rs      : '0;
      rt_p1     <= capture ? id_rt      : '0;
      rd_p1     <= capture ? id_rd      : '0;
      // Empty-ID bubbles are idle slots, not lost work, so they are not counted
      if (flush || hazardStall) begin
        bubbleCnt <= satInc(bubbleCnt);
      end
    end
  end

  assign ex_valid     = vld_p1;
  assign ex_ctrl      = ctrl_p1;
  assign ex_pc4       = pc4_p1;
  assign ex_rs_data   = rsData_p1;
  assign ex_rt_data   = rtData_p1;
  assign ex_imm       = imm_p1;
  assign ex_rs        = rs_p1;
  assign ex_rt        = rt_p1;
  assign ex_rd        = rd_p1;
  assign hazard_stall = hazardStall;
  assign bubble_count = bubbleCnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a transaction-level model predicts the EX
// contents after each edge; a monitor compares them against the DUT.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 4;

  localparam logic [9:0] C_RTYPE = 10'b1_0_0_0_10_0_0_1_0;
  localparam logic [9:0] C_LW    = 10'b0_0_1_1_00_0_1_1_0;
  localparam logic [9:0] C_SW    = 10'b0_0_0_0_00_1_1_0_0;
  localparam logic [9:0] C_BEQ   = 10'b0_1_0_0_01_0_0_0_0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          id_valid = 1'b0;
  logic [9:0]    id_ctrl = '0;
  logic [DW-1:0] id_pc4 = '0, id_rs_data = '0, id_rt_data = '0, id_imm = '0;
  logic [RW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic          flush = 1'b0;
  logic          ex_valid;
  logic [9:0]    ex_ctrl;
  logic [DW-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [RW-1:0] ex_rs, ex_rt, ex_rd;
  logic          hazard_stall;
  logic [CW-1:0] bubble_count;

  id_ex_stage #(.DATA_W(DW), .REG_W(RW), .COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .flush(flush), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .hazard_stall(hazard_stall), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [9:0]    ctrl;
    logic [DW-1:0] pc4, rsd, rtd, imm;
    logic [RW-1:0] rs, rt, rd;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t m;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic exp_t bubbleOf(input logic [CW-1:0] cnt);
    exp_t b;
    b.v = 1'b0; b.ctrl = '0; b.pc4 = '0; b.rsd = '0; b.rtd = '0; b.imm = '0;
    b.rs = '0; b.rt = '0; b.rd = '0; b.cnt = cnt;
    return b;
  endfunction

  // Monitor: after every edge the EX stage must match the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("ex_valid", ex_valid, e.v);
        check("ex_ctrl", ex_ctrl, e.ctrl);
        check("ex_pc4", ex_pc4, e.pc4);
        check("ex_rs_data", ex_rs_data, e.rsd);
        check("ex_rt_data", ex_rt_data, e.rtd);
        check("ex_imm", ex_imm, e.imm);
        check("ex_rs", ex_rs, e.rs);
        check("ex_rt", ex_rt, e.rt);
        check("ex_rd", ex_rd, e.rd);
        check("bubble_count", bubble_count, e.cnt);
      end
    end
  end

  // Present one ID slot (called at a falling edge), predict, and advance one cycle
  task automatic step(input logic v, input logic [9:0] c, input logic [RW-1:0] rs,
                      input logic [RW-1:0] rt, input logic [RW-1:0] rd,
                      input logic [DW-1:0] rsd, input logic [DW-1:0] rtd,
                      input logic [DW-1:0] imm, input logic [DW-1:0] pc4,
                      input logic fl, output logic stalled);
    logic loadInEx, readsIt, expHaz;
    id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_pc4 = pc4; flush = fl;
    #1;
    loadInEx = m.v && m.ctrl[7] && m.ctrl[1] && (m.rt != 0);
    readsIt  = v && ((m.rt == rs) || (m.rt == rt));
    expHaz   = loadInEx && readsIt && !fl;
    check("hazard_stall", hazard_stall, expHaz);
    if (fl || expHaz) m = bubbleOf((m.cnt == 4'hF) ? m.cnt : m.cnt + 1);
    else if (!v) m = bubbleOf(m.cnt);
    else begin
      m.v = 1'b1; m.ctrl = c; m.pc4 = pc4; m.rsd = rsd; m.rtd = rtd; m.imm = imm;
      m.rs = rs; m.rt = rt; m.rd = rd;
    end
    q.push_back(m);
    stalled = expHaz;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    id_valid = 1'b0; flush = 1'b0;
    #1;
    check("rst_valid", ex_valid, 0);
    check("rst_ctrl", ex_ctrl, 0);
    check("rst_pc4", ex_pc4, 0);
    check("rst_rsd", ex_rs_data, 0);
    check("rst_rtd", ex_rt_data, 0);
    check("rst_imm", ex_imm, 0);
    check("rst_regs", {ex_rs, ex_rt, ex_rd}, 0);
    check("rst_count", bubble_count, 0);
    check("rst_hazard", hazard_stall, 0);
    q.delete();
    m = bubbleOf('0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic st;
    int   guard;
    m = bubbleOf('0);
    doReset();

    // R-type add $3,$1,$2 passes through unchanged
    step(1, C_RTYPE, 1, 2, 3, 7, 9, 0, 32'h104, 0, st);
    check("pt_ctrl", ex_ctrl, 10'b1000100010);
    check("pt_rsd", ex_rs_data, 7);
    check("pt_rtd", ex_rt_data, 9);
    check("pt_rd", ex_rd, 3);
    check("pt_valid", ex_valid, 1);

    // lw $5,0($1) ; add $6,$5,$2 -> one stall
    doReset();
    step(1, C_LW, 1, 5, 0, 32'h40, 32'h11, 0, 32'h200, 0, st);
    step(1, C_RTYPE, 5, 2, 6, 32'h22, 32'h33, 0, 32'h204, 0, st);
    check("lu_bubble_valid", ex_valid, 0);
    step(1, C_RTYPE, 5, 2, 6, 32'h22, 32'h33, 0, 32'h204, 0, st);
    check("lu_add_valid", ex_valid, 1);
    check("lu_add_rd", ex_rd, 6);
    check("lu_count", bubble_count, 1);

    // Load to $0 never stalls
    doReset();
    step(1, C_LW, 1, 0, 0, 32'h40, 0, 4, 32'h300, 0, st);
    step(1, C_RTYPE, 0, 2, 6, 0, 32'h5, 0, 32'h304, 0, st);
    check("z_valid", ex_valid, 1);
    check("z_rd", ex_rd, 6);
    check("z_count", bubble_count, 0);

    // Flush coinciding with a hazard counts once
    doReset();
    step(1, C_LW, 1, 5, 0, 32'h40, 0, 0, 32'h400, 0, st);
    step(1, C_RTYPE, 5, 2, 6, 0, 0, 0, 32'h404, 1, st);
    check("fh_valid", ex_valid, 0);
    check("fh_count", bubble_count, 1);

    // Back-to-back dependent loads: two separate stalls
    doReset();
    step(1, C_LW, 1, 5, 0, 1, 2, 0, 32'h500, 0, st);
    step(1, C_LW, 5, 7, 0, 3, 4, 8, 32'h504, 0, st);
    step(1, C_LW, 5, 7, 0, 3, 4, 8, 32'h504, 0, st);
    step(1, C_RTYPE, 7, 2, 9, 5, 6, 0, 32'h508, 0, st);
    step(1, C_RTYPE, 7, 2, 9, 5, 6, 0, 32'h508, 0, st);
    check("b2b_count", bubble_count, 2);
    check("b2b_rd", ex_rd, 9);

    // Store and beq reading the load target via rt still stall
    doReset();
    step(1, C_LW, 1, 5, 0, 0, 0, 0, 32'h600, 0, st);
    step(1, C_SW, 2, 5, 0, 0, 0, 0, 32'h604, 0, st);
    step(1, C_SW, 2, 5, 0, 0, 0, 0, 32'h604, 0, st);
    step(1, C_LW, 1, 4, 0, 0, 0, 0, 32'h608, 0, st);
    step(1, C_BEQ, 3, 4, 0, 0, 0, 0, 32'h60C, 0, st);
    step(1, C_BEQ, 3, 4, 0, 0, 0, 0, 32'h60C, 0, st);
    check("st_beq_count", bubble_count, 2);

    // Reset mid-stream with valid EX and count 5
    doReset();
    for (int i = 0; i < 5; i++) step($urandom_range(0, 1), C_RTYPE, 1, 2, 3, 0, 0, 0, 0, 1, st);
    step(1, C_RTYPE, 1, 2, 3, 32'hAA, 32'hBB, 0, 32'h700, 0, st);
    check("mr_valid_before", ex_valid, 1);
    check("mr_count_before", bubble_count, 5);
    doReset();
    step(1, C_RTYPE, 4, 5, 6, 32'hCC, 32'hDD, 0, 32'h704, 0, st);
    check("mr_first_valid", ex_valid, 1);
    check("mr_first_rsd", ex_rs_data, 32'hCC);

    // Saturation of the 4-bit counter
    doReset();
    for (int i = 0; i < 20; i++) step(1, C_RTYPE, 1, 2, 3, 0, 0, 0, 0, 1, st);
    check("sat_count", bubble_count, 15);
    for (int i = 0; i < 5; i++) step(0, C_RTYPE, 1, 2, 3, 0, 0, 0, 0, 0, st);
    check("sat_hold", bubble_count, 15);
    doReset();
    for (int i = 0; i < 4; i++) step(0, C_LW, 1, 2, 3, 0, 0, 0, 0, 0, st);
    check("idle_nocount", bubble_count, 0);

    // Randomized instruction stream; a stalled ID slot is re-presented
    for (int n = 0; n < 300; n++) begin
      logic [9:0] c;
      logic [RW-1:0] rs, rt, rd;
      logic [DW-1:0] rsd, rtd, imm, pc4;
      logic v, fl;
      if (n % 60 == 59) doReset();
      case ($urandom_range(0, 4))
        0: c = C_LW;
        1: c = C_RTYPE;
        2: c = C_SW;
        3: c = C_BEQ;
        default: c = 10'($urandom);
      endcase
      rs = RW'($urandom_range(0, 7)); rt = RW'($urandom_range(0, 7));
      rd = RW'($urandom_range(0, 31));
      rsd = $urandom; rtd = $urandom; imm = $urandom; pc4 = $urandom;
      v  = ($urandom_range(0, 9) < 8);
      fl = ($urandom_range(0, 9) == 0);
      step(v, c, rs, rt, rd, rsd, rtd, imm, pc4, fl, st);
      guard = 0;
      while (st && guard < 4) begin
        step(v, c, rs, rt, rd, rsd, rtd, imm, pc4, ($urandom_range(0, 9) == 0), st);
        guard++;
      end
      check("stall_bound", st, 0);
    end

    @(posedge clk);
    #2;
    check("sb_drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
